// File: rtl/mfb_frame_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mfb_frame_checker: one-stage MFB register that measures frame lengths,       |
// | flags SOF/EOF violations per region at EOF and counts them.  Rev 1.0         |
// +-----------------------------------------------------------------------------+
module mfb_frame_checker #(
  parameter int REGIONS        = 4,
  parameter int REGION_SIZE    = 8,
  parameter int BLOCK_SIZE     = 8,
  parameter int ITEM_WIDTH     = 8,
  parameter int FRAME_SIZE_MIN = 60,
  parameter int FRAME_SIZE_MAX = 512,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                                                 CLK,
  input  logic                                                 RESET_N,
  input  logic [REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] RX_DATA,
  input  logic [REGIONS*$clog2(REGION_SIZE)-1:0]               RX_SOF_POS,
  input  logic [REGIONS*$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]    RX_EOF_POS,
  input  logic [REGIONS-1:0]                                   RX_SOF,
  input  logic [REGIONS-1:0]                                   RX_EOF,
  input  logic                                                 RX_SRC_RDY,
  output logic                                                 RX_DST_RDY,
  output logic [REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] TX_DATA,
  output logic [REGIONS*$clog2(REGION_SIZE)-1:0]               TX_SOF_POS,
  output logic [REGIONS*$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]    TX_EOF_POS,
  output logic [REGIONS-1:0]                                   TX_SOF,
  output logic [REGIONS-1:0]                                   TX_EOF,
  output logic [REGIONS-1:0]                                   TX_ERR,
  output logic                                                 TX_SRC_RDY,
  input  logic                                                 TX_DST_RDY,
  input  logic                                                 CNT_CLR,
  output logic [CNT_WIDTH-1:0]                                 CNT_FRAMES,
  output logic [CNT_WIDTH-1:0]                                 CNT_ERR_LEN,
  output logic [CNT_WIDTH-1:0]                                 CNT_ERR_PROT
);

  localparam int DATA_W       = REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH;
  localparam int SOF_POS_W    = $clog2(REGION_SIZE);
  localparam int EOF_POS_W    = $clog2(REGION_SIZE*BLOCK_SIZE);
  localparam int REGION_ITEMS = REGION_SIZE*BLOCK_SIZE;
  localparam int LEN_SAT      = FRAME_SIZE_MAX + 1;
  localparam int LEN_W        = $clog2(FRAME_SIZE_MAX + 2);
  localparam int INC_W        = $clog2(REGIONS + 1);

  logic [DATA_W-1:0]              tx_data_q, tx_data_d;
  logic [REGIONS*SOF_POS_W-1:0]   tx_sof_pos_q, tx_sof_pos_d;
  logic [REGIONS*EOF_POS_W-1:0]   tx_eof_pos_q, tx_eof_pos_d;
  logic [REGIONS-1:0]             tx_sof_q, tx_sof_d, tx_eof_q, tx_eof_d, tx_err_q, tx_err_d;
  logic                           tx_src_rdy_q, tx_src_rdy_d;
  logic                           in_frame_q, in_frame_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic [CNT_WIDTH-1:0]           cnt_frames_q, cnt_frames_d;
  logic [CNT_WIDTH-1:0]           cnt_err_len_q, cnt_err_len_d;
  logic [CNT_WIDTH-1:0]           cnt_err_prot_q, cnt_err_prot_d;
  logic [REGIONS-1:0]             err_d;
  logic [INC_W-1:0]               inc_frames, inc_len, inc_prot;
  logic                           rx_xfer;

  assign RX_DST_RDY = TX_DST_RDY | ~tx_src_rdy_q;
  assign rx_xfer    = RX_SRC_RDY & RX_DST_RDY;

  // Keeps the accumulator bounded; anything past FRAME_SIZE_MAX is already too long.
  function automatic int sat_len(input int v);
    return (v > LEN_SAT) ? LEN_SAT : v;
  endfunction

  function automatic logic len_bad(input int v);
    return (v < FRAME_SIZE_MIN) || (v > FRAME_SIZE_MAX);
  endfunction

  always_comb begin : p_frame
    int   len_v;
    int   offset_v;
    int   end_v;
    logic in_v;
    in_v       = in_frame_q;
    len_v      = int'(len_q);
    offset_v   = 0;
    end_v      = 0;
    err_d      = '0;
    inc_frames = '0;
    inc_len    = '0;
    inc_prot   = '0;
    if (rx_xfer) begin
      for (int r = 0; r < REGIONS; r++) begin
        offset_v = int'(RX_SOF_POS[r*SOF_POS_W +: SOF_POS_W]) * BLOCK_SIZE;
        end_v    = int'(RX_EOF_POS[r*EOF_POS_W +: EOF_POS_W]);
        if (RX_EOF[r] && in_v) begin
          len_v      = sat_len(len_v + end_v + 1);
          inc_frames = inc_frames + INC_W'(1);
          if (len_bad(len_v)) begin
            err_d[r] = 1'b1;
            inc_len  = inc_len + INC_W'(1);
          end
          in_v = 1'b0;
          if (RX_SOF[r]) begin
            // A new SOF at or before the closing EOF overlaps the old frame.
            if (offset_v <= end_v) begin
              err_d[r] = 1'b1;
              inc_prot = inc_prot + INC_W'(1);
            end
            in_v  = 1'b1;
            len_v = REGION_ITEMS - offset_v;
          end
        end else if (RX_EOF[r]) begin
          if (!RX_SOF[r] || (end_v < offset_v)) begin
            err_d[r] = 1'b1;
            inc_prot = inc_prot + INC_W'(1);
          end else begin
            len_v      = end_v + 1 - offset_v;
            inc_frames = inc_frames + INC_W'(1);
            if (len_bad(len_v)) begin
              err_d[r] = 1'b1;
              inc_len  = inc_len + INC_W'(1);
            end
          end
        end else if (RX_SOF[r]) begin
          if (in_v) begin
            inc_prot = inc_prot + INC_W'(1);
          end
          in_v  = 1'b1;
          len_v = REGION_ITEMS - offset_v;
        end else if (in_v) begin
          len_v = sat_len(len_v + REGION_ITEMS);
        end
      end
    end
    in_frame_d = in_v;
    len_d      = LEN_W'(len_v);
  end

  always_comb begin
    tx_data_d    = tx_data_q;
    tx_sof_pos_d = tx_sof_pos_q;
    tx_eof_pos_d = tx_eof_pos_q;
    tx_sof_d     = tx_sof_q;
    tx_eof_d     = tx_eof_q;
    tx_err_d     = tx_err_q;
    tx_src_rdy_d = tx_src_rdy_q;
    if (RX_DST_RDY) begin
      tx_data_d    = RX_DATA;
      tx_sof_pos_d = RX_SOF_POS;
      tx_eof_pos_d = RX_EOF_POS;
      tx_sof_d     = RX_SOF;
      tx_eof_d     = RX_EOF;
      tx_err_d     = err_d;
      tx_src_rdy_d = RX_SRC_RDY;
    end
    cnt_frames_d   = CNT_CLR ? '0 : cnt_frames_q   + CNT_WIDTH'(inc_frames);
    cnt_err_len_d  = CNT_CLR ? '0 : cnt_err_len_q  + CNT_WIDTH'(inc_len);
    cnt_err_prot_d = CNT_CLR ? '0 : cnt_err_prot_q + CNT_WIDTH'(inc_prot);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_data_q      <= '0;
      tx_sof_pos_q   <= '0;
      tx_eof_pos_q   <= '0;
      tx_sof_q       <= '0;
      tx_eof_q       <= '0;
      tx_err_q       <= '0;
      tx_src_rdy_q   <= 1'b0;
      in_frame_q     <= 1'b0;
      len_q          <= '0;
      cnt_frames_q   <= '0;
      cnt_err_len_q  <= '0;
      cnt_err_prot_q <= '0;
    end else begin
      tx_data_q      <= tx_data_d;
      tx_sof_pos_q   <= tx_sof_pos_d;
      tx_eof_pos_q   <= tx_eof_pos_d;
      tx_sof_q       <= tx_sof_d;
      tx_eof_q       <= tx_eof_d;
      tx_err_q       <= tx_err_d;
      tx_src_rdy_q   <= tx_src_rdy_d;
      in_frame_q     <= in_frame_d;
      len_q          <= len_d;
      cnt_frames_q   <= cnt_frames_d;
      cnt_err_len_q  <= cnt_err_len_d;
      cnt_err_prot_q <= cnt_err_prot_d;
    end
  end

  assign TX_DATA      = tx_data_q;
  assign TX_SOF_POS   = tx_sof_pos_q;
  assign TX_EOF_POS   = tx_eof_pos_q;
  assign TX_SOF       = tx_sof_q;
  assign TX_EOF       = tx_eof_q;
  assign TX_ERR       = tx_err_q;
  assign TX_SRC_RDY   = tx_src_rdy_q;
  assign CNT_FRAMES   = cnt_frames_q;
  assign CNT_ERR_LEN  = cnt_err_len_q;
  assign CNT_ERR_PROT = cnt_err_prot_q;

endmodule
`default_nettype wire

// File: tb/tb_mfb_frame_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mfb_frame_checker: directed self-checking bench for mfb_frame_checker.    |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module tb_mfb_frame_checker;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2047:0] rx_data, tx_data;
  logic [11:0]   rx_sof_pos, tx_sof_pos;
  logic [23:0]   rx_eof_pos, tx_eof_pos;
  logic [3:0]    rx_sof, rx_eof, tx_sof, tx_eof, tx_err;
  logic          rx_src_rdy, rx_dst_rdy, tx_src_rdy, tx_dst_rdy, cnt_clr;
  logic [31:0]   cnt_frames, cnt_err_len, cnt_err_prot;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  mfb_frame_checker dut (
    .CLK(clk), .RESET_N(rst_n),
    .RX_DATA(rx_data), .RX_SOF_POS(rx_sof_pos), .RX_EOF_POS(rx_eof_pos),
    .RX_SOF(rx_sof), .RX_EOF(rx_eof), .RX_SRC_RDY(rx_src_rdy), .RX_DST_RDY(rx_dst_rdy),
    .TX_DATA(tx_data), .TX_SOF_POS(tx_sof_pos), .TX_EOF_POS(tx_eof_pos),
    .TX_SOF(tx_sof), .TX_EOF(tx_eof), .TX_ERR(tx_err),
    .TX_SRC_RDY(tx_src_rdy), .TX_DST_RDY(tx_dst_rdy),
    .CNT_CLR(cnt_clr), .CNT_FRAMES(cnt_frames), .CNT_ERR_LEN(cnt_err_len),
    .CNT_ERR_PROT(cnt_err_prot)
  );

  function automatic logic [2047:0] pat(input logic [31:0] s);
    return {64{s}};
  endfunction

  // Presents one word, lets it transfer on the next edge, samples just after.
  task automatic send(input logic [3:0] sof, input logic [3:0] eof,
                      input logic [11:0] sp, input logic [23:0] ep, input logic [31:0] seed);
    rx_sof = sof; rx_eof = eof; rx_sof_pos = sp; rx_eof_pos = ep;
    rx_data = pat(seed); rx_src_rdy = 1'b1;
    @(posedge clk); #1;
    rx_src_rdy = 1'b0; rx_sof = '0; rx_eof = '0;
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_dst_rdy = 1'b1; cnt_clr = 1'b0; rx_src_rdy = 1'b0;
    rx_sof = '0; rx_eof = '0; rx_sof_pos = '0; rx_eof_pos = '0; rx_data = '0;
    repeat (2) @(posedge clk); #1;
    checks++; if (tx_src_rdy !== 1'b0) begin failures++; $display("FAIL reset_src_rdy got=%b exp=0", tx_src_rdy); end
    checks++; if ({tx_sof, tx_eof, tx_err} !== 12'h0) begin failures++; $display("FAIL reset_flags got=%h exp=000", {tx_sof, tx_eof, tx_err}); end
    checks++; if ({cnt_frames, cnt_err_len, cnt_err_prot} !== 96'h0) begin failures++; $display("FAIL reset_counters got=%h exp=0", {cnt_frames, cnt_err_len, cnt_err_prot}); end
    checks++; if (rx_dst_rdy !== 1'b1) begin failures++; $display("FAIL reset_dst_rdy got=%b exp=1", rx_dst_rdy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_legal();
    send(4'b0001, 4'b0001, 12'd0, 24'd59, 32'h1111_0001);
    checks++; if (tx_src_rdy !== 1'b1) begin failures++; $display("FAIL legal_src_rdy got=%b exp=1", tx_src_rdy); end
    checks++; if (tx_data !== pat(32'h1111_0001)) begin failures++; $display("FAIL legal_data got=%h exp=%h", tx_data[31:0], 32'h1111_0001); end
    checks++; if ({tx_sof, tx_eof, tx_eof_pos} !== {4'b0001, 4'b0001, 24'd59}) begin failures++; $display("FAIL legal_ctrl got=%h", {tx_sof, tx_eof, tx_eof_pos}); end
    checks++; if (tx_err !== 4'b0000) begin failures++; $display("FAIL legal_err got=%b exp=0000", tx_err); end
    checks++; if (cnt_frames !== 32'd1) begin failures++; $display("FAIL legal_frames got=%0d exp=1", cnt_frames); end
    @(posedge clk); #1;
    checks++; if (tx_src_rdy !== 1'b0) begin failures++; $display("FAIL legal_idle got=%b exp=0", tx_src_rdy); end
  endtask

  task automatic test_short();
    clear_counters();
    send(4'b0001, 4'b0001, 12'd0, 24'd58, 32'h2222_0001);
    checks++; if (tx_err !== 4'b0001) begin failures++; $display("FAIL short_err got=%b exp=0001", tx_err); end
    checks++; if (cnt_err_len !== 32'd1) begin failures++; $display("FAIL short_len_cnt got=%0d exp=1", cnt_err_len); end
    checks++; if (cnt_frames !== 32'd1) begin failures++; $display("FAIL short_frames got=%0d exp=1", cnt_frames); end
  endtask

  task automatic test_long();
    clear_counters();
    send(4'b0001, 4'b0000, 12'd0, 24'd0, 32'h3333_0001);
    send(4'b0000, 4'b0000, 12'd0, 24'd0, 32'h3333_0002);
    checks++; if (tx_eof !== 4'b0000 || tx_src_rdy !== 1'b1) begin failures++; $display("FAIL long_mid got=%b/%b exp=0000/1", tx_eof, tx_src_rdy); end
    send(4'b0000, 4'b0001, 12'd0, 24'd0, 32'h3333_0003);
    checks++; if (tx_err !== 4'b0001) begin failures++; $display("FAIL long513_err got=%b exp=0001", tx_err); end
    checks++; if (cnt_err_len !== 32'd1 || cnt_frames !== 32'd1) begin failures++; $display("FAIL long513_cnt got=%0d/%0d exp=1/1", cnt_err_len, cnt_frames); end
    send(4'b0001, 4'b0000, 12'd0, 24'd0, 32'h3333_0004);
    send(4'b0000, 4'b1000, 12'd0, 24'd63 << 18, 32'h3333_0005);
    checks++; if (tx_err !== 4'b0000) begin failures++; $display("FAIL long512_err got=%b exp=0000", tx_err); end
    checks++; if (cnt_err_len !== 32'd1 || cnt_frames !== 32'd2) begin failures++; $display("FAIL long512_cnt got=%0d/%0d exp=1/2", cnt_err_len, cnt_frames); end
  endtask

  task automatic test_protocol();
    clear_counters();
    send(4'b0000, 4'b0010, 12'd0, 24'd0, 32'h4444_0001);
    checks++; if (tx_err !== 4'b0010) begin failures++; $display("FAIL prot_eof_err got=%b exp=0010", tx_err); end
    checks++; if (cnt_err_prot !== 32'd1) begin failures++; $display("FAIL prot_eof_cnt got=%0d exp=1", cnt_err_prot); end
    send(4'b0101, 4'b0000, 12'd0, 24'd0, 32'h4444_0002);
    checks++; if (cnt_err_prot !== 32'd2 || cnt_frames !== 32'd0) begin failures++; $display("FAIL prot_sof_cnt got=%0d/%0d exp=2/0", cnt_err_prot, cnt_frames); end
    send(4'b0000, 4'b0001, 12'd0, 24'd63, 32'h4444_0003);
    checks++; if (tx_err !== 4'b0000 || cnt_frames !== 32'd1) begin failures++; $display("FAIL prot_close got=%b/%0d exp=0000/1", tx_err, cnt_frames); end
  endtask

  task automatic test_sof_eof_overlap();
    clear_counters();
    send(4'b1000, 4'b0000, 12'd0, 24'd0, 32'h5555_0001);
    send(4'b0001, 4'b0001, 12'd0, 24'd3, 32'h5555_0002);
    checks++; if (tx_err !== 4'b0001) begin failures++; $display("FAIL overlap_err got=%b exp=0001", tx_err); end
    checks++; if (cnt_frames !== 32'd1 || cnt_err_prot !== 32'd1 || cnt_err_len !== 32'd0) begin failures++; $display("FAIL overlap_cnt got=%0d/%0d/%0d exp=1/1/0", cnt_frames, cnt_err_prot, cnt_err_len); end
    send(4'b0000, 4'b0001, 12'd0, 24'd63, 32'h5555_0003);
    checks++; if (tx_err !== 4'b0000 || cnt_frames !== 32'd2) begin failures++; $display("FAIL overlap_close got=%b/%0d exp=0000/2", tx_err, cnt_frames); end
    send(4'b0001, 4'b0001, 12'd2, 24'd10, 32'h5555_0004);
    checks++; if (tx_err !== 4'b0001 || cnt_err_prot !== 32'd2 || cnt_frames !== 32'd2) begin failures++; $display("FAIL inverted_single got=%b/%0d/%0d exp=0001/2/2", tx_err, cnt_err_prot, cnt_frames); end
  endtask

  task automatic test_back_to_back();
    clear_counters();
    send(4'b0011, 4'b0001, 12'd0, 24'd63, 32'h6666_0001);
    checks++; if (tx_err !== 4'b0000 || cnt_frames !== 32'd1 || cnt_err_prot !== 32'd0) begin failures++; $display("FAIL b2b_first got=%b/%0d/%0d exp=0000/1/0", tx_err, cnt_frames, cnt_err_prot); end
    send(4'b0000, 4'b0001, 12'd0, 24'd59, 32'h6666_0002);
    checks++; if (tx_err !== 4'b0000 || cnt_frames !== 32'd2) begin failures++; $display("FAIL b2b_second got=%b/%0d exp=0000/2", tx_err, cnt_frames); end
  endtask

  task automatic test_multi_region();
    clear_counters();
    send(4'b1111, 4'b1111, 12'd0, {4{6'd63}}, 32'h7777_0001);
    checks++; if (cnt_frames !== 32'd4 || tx_err !== 4'b0000) begin failures++; $display("FAIL multi_ok got=%0d/%b exp=4/0000", cnt_frames, tx_err); end
    send(4'b1111, 4'b1111, 12'd0, {4{6'd5}}, 32'h7777_0002);
    checks++; if (cnt_err_len !== 32'd4 || cnt_frames !== 32'd8 || tx_err !== 4'b1111) begin failures++; $display("FAIL multi_short got=%0d/%0d/%b exp=4/8/1111", cnt_err_len, cnt_frames, tx_err); end
  endtask

  task automatic test_cnt_clr();
    cnt_clr = 1'b1;
    send(4'b0001, 4'b0001, 12'd0, 24'd5, 32'h8888_0001);
    cnt_clr = 1'b0;
    checks++; if ({cnt_frames, cnt_err_len} !== 64'h0) begin failures++; $display("FAIL clr_priority got=%0d/%0d exp=0/0", cnt_frames, cnt_err_len); end
    checks++; if (tx_src_rdy !== 1'b1 || tx_err !== 4'b0001) begin failures++; $display("FAIL clr_stream got=%b/%b exp=1/0001", tx_src_rdy, tx_err); end
  endtask

  task automatic test_backpressure();
    clear_counters();
    tx_dst_rdy = 1'b0;
    send(4'b0001, 4'b0001, 12'd0, 24'd59, 32'h9999_000A);
    checks++; if (cnt_frames !== 32'd1 || rx_dst_rdy !== 1'b0) begin failures++; $display("FAIL bp_first got=%0d/%b exp=1/0", cnt_frames, rx_dst_rdy); end
    rx_sof = 4'b0001; rx_eof = 4'b0001; rx_sof_pos = '0; rx_eof_pos = 24'd58;
    rx_data = pat(32'h9999_000B); rx_src_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx_data !== pat(32'h9999_000A) || tx_eof_pos !== 24'd59 || tx_src_rdy !== 1'b1 ||
          rx_dst_rdy !== 1'b0 || cnt_frames !== 32'd1 || cnt_err_len !== 32'd0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got data=%h pos=%0d rdy=%b/%b frames=%0d len=%0d exp data=9999000a pos=59 rdy=1/0 frames=1 len=0",
                 i, tx_data[31:0], tx_eof_pos, tx_src_rdy, rx_dst_rdy, cnt_frames, cnt_err_len);
      end
    end
    tx_dst_rdy = 1'b1;
    @(posedge clk); #1;
    rx_src_rdy = 1'b0; rx_sof = '0; rx_eof = '0;
    checks++; if (tx_data !== pat(32'h9999_000B) || tx_eof_pos !== 24'd58 || tx_err !== 4'b0001) begin failures++; $display("FAIL bp_release got=%h/%0d/%b exp=9999000b/58/0001", tx_data[31:0], tx_eof_pos, tx_err); end
    checks++; if (cnt_frames !== 32'd2 || cnt_err_len !== 32'd1) begin failures++; $display("FAIL bp_release_cnt got=%0d/%0d exp=2/1", cnt_frames, cnt_err_len); end
  endtask

  task automatic test_reset_midframe();
    send(4'b0001, 4'b0000, 12'd0, 24'd0, 32'hAAAA_0001);
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (tx_src_rdy !== 1'b0 || tx_data !== '0 || {cnt_frames, cnt_err_len} !== 64'h0) begin failures++; $display("FAIL rst_mid_outputs got=%b/%0d/%0d exp=0/0/0", tx_src_rdy, cnt_frames, cnt_err_len); end
    @(negedge clk); rst_n = 1'b1;
    send(4'b0000, 4'b0001, 12'd0, 24'd10, 32'hAAAA_0002);
    checks++; if (tx_err !== 4'b0001 || cnt_err_prot !== 32'd1 || cnt_frames !== 32'd0) begin failures++; $display("FAIL rst_mid_eof got=%b/%0d/%0d exp=0001/1/0", tx_err, cnt_err_prot, cnt_frames); end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_short();
    test_long();
    test_protocol();
    test_sof_eof_overlap();
    test_back_to_back();
    test_multi_region();
    test_cnt_clr();
    test_backpressure();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
